// File: rtl/neat_gene_pkg.sv
// Shared constants, gene field layout and controller state encoding for the
// NEAT child-genome generation pass.
package neat_gene_pkg;

  localparam int unsigned GENE_SZ = 64;
  localparam int unsigned ATTR_SZ = 8;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned NUM_RND = 4;

  localparam int unsigned KEY_LSB  = 48;
  localparam int unsigned KEY_W    = 16;
  localparam int unsigned TYPE_BIT = 47;
  localparam int unsigned A1_LSB   = 32;
  localparam int unsigned A2_LSB   = 24;
  localparam int unsigned A3_LSB   = 16;
  localparam int unsigned SRC_LSB  = 8;
  localparam int unsigned DST_LSB  = 0;

  localparam logic [7:0] HALF         = 8'h40;
  localparam logic [7:0] NODE_A2_MASK = 8'h0F;
  localparam logic [7:0] NODE_A3_MASK = 8'h07;
  localparam logic [7:0] CONN_A1_MASK = 8'h01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_RAND,
    S_COMPOSE,
    S_WRITE,
    S_DONE
  } state_e;

endpackage

// File: rtl/gene_xover_mutate_ctrl_if.sv
// Parent read, RNG and child write ports of the gene crossover/mutation
// controller; master is the controller side.
interface gene_xover_mutate_ctrl_if #(
  parameter int unsigned GENE_SZ = neat_gene_pkg::GENE_SZ,
  parameter int unsigned ADDR_W  = neat_gene_pkg::ADDR_W,
  parameter int unsigned ATTR_SZ = neat_gene_pkg::ATTR_SZ
);
  logic               p1_rd_en;
  logic               p2_rd_en;
  logic [ADDR_W-1:0]  p_addr;
  logic [GENE_SZ-1:0] p1_rd_data;
  logic [GENE_SZ-1:0] p2_rd_data;
  logic               rnd_req;
  logic               rnd_valid;
  logic [ATTR_SZ-1:0] rnd_data;
  logic               child_wr_en;
  logic               child_wr_ready;
  logic [ADDR_W-1:0]  child_addr;
  logic [GENE_SZ-1:0] child_wr_data;

  modport master (
    output p1_rd_en, p2_rd_en, p_addr, rnd_req, child_wr_en, child_addr, child_wr_data,
    input  p1_rd_data, p2_rd_data, rnd_valid, rnd_data, child_wr_ready
  );

  modport slave (
    input  p1_rd_en, p2_rd_en, p_addr, rnd_req, child_wr_en, child_addr, child_wr_data,
    output p1_rd_data, p2_rd_data, rnd_valid, rnd_data, child_wr_ready
  );
endinterface

// File: rtl/gene_child_compose.sv
// Combinational child-gene composition: parent select, masked mutation and
// deleted-node match for connection genes.
module gene_child_compose
  import neat_gene_pkg::*;
(
  input  logic [GENE_SZ-1:0]         gene1,
  input  logic [GENE_SZ-1:0]         gene2,
  input  logic                       bias,
  input  logic [7:0]                 mutation_prob,
  input  logic [GENE_SZ-1:0]         del_node_list,
  input  logic [NUM_RND*ATTR_SZ-1:0] rnd,
  output logic [GENE_SZ-1:0]         child,
  output logic                       skip
);
  logic [7:0]         r0, r1, r2, r3;
  logic               sel;
  logic [GENE_SZ-1:0] g;
  logic               is_conn;
  logic [7:0]         a1, a2, a3, src, dst, slot;

  assign r0 = rnd[0*ATTR_SZ +: ATTR_SZ];
  assign r1 = rnd[1*ATTR_SZ +: ATTR_SZ];
  assign r2 = rnd[2*ATTR_SZ +: ATTR_SZ];
  assign r3 = rnd[3*ATTR_SZ +: ATTR_SZ];

  always_comb begin
    sel = bias;
    if ((gene1[KEY_LSB +: KEY_W] == gene2[KEY_LSB +: KEY_W]) && (r0 > HALF)) begin
      sel = ~bias;
    end
    g       = sel ? gene2 : gene1;
    is_conn = g[TYPE_BIT];
    a1      = g[A1_LSB +: ATTR_SZ];
    a2      = g[A2_LSB +: ATTR_SZ];
    a3      = g[A3_LSB +: ATTR_SZ];
    src     = g[SRC_LSB +: ATTR_SZ];
    dst     = g[DST_LSB +: ATTR_SZ];

    if (r1 <= mutation_prob) begin
      case (r2[1:0])
        2'd0:    a1 = is_conn ? (r3 & CONN_A1_MASK) : r3;
        2'd1:    a2 = is_conn ? '0 : (r3 & NODE_A2_MASK);
        2'd2:    a3 = is_conn ? '0 : (r3 & NODE_A3_MASK);
        default: ;
      endcase
    end

    child                       = '0;
    child[KEY_LSB +: KEY_W]     = g[KEY_LSB +: KEY_W];
    child[TYPE_BIT]             = is_conn;
    child[A1_LSB +: ATTR_SZ]    = a1;
    child[A2_LSB +: ATTR_SZ]    = a2;
    child[A3_LSB +: ATTR_SZ]    = a3;
    child[SRC_LSB +: ATTR_SZ]   = src;
    child[DST_LSB +: ATTR_SZ]   = dst;

    // Zero slots are empty and must never match a node id of 0.
    skip = 1'b0;
    slot = '0;
    for (int unsigned i = 0; i < GENE_SZ / ATTR_SZ; i++) begin
      slot = del_node_list[i*ATTR_SZ +: ATTR_SZ];
      if (is_conn && (slot != '0) && ((slot == src) || (slot == dst))) begin
        skip = 1'b1;
      end
    end
  end
endmodule

// File: rtl/gene_xover_mutate_ctrl.sv
// Sequencer for one child-genome generation pass: reads aligned parent gene
// pairs, draws random bytes, composes and writes compacted child genes.
module gene_xover_mutate_ctrl
  import neat_gene_pkg::*;
#(
  parameter int unsigned GENE_SZ = neat_gene_pkg::GENE_SZ,
  parameter int unsigned ATTR_SZ = neat_gene_pkg::ATTR_SZ,
  parameter int unsigned ADDR_W  = neat_gene_pkg::ADDR_W,
  parameter int unsigned NUM_RND = neat_gene_pkg::NUM_RND
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    gene_count,
  input  logic                 bias,
  input  logic [7:0]           mutation_prob,
  input  logic [GENE_SZ-1:0]   del_node_list,
  gene_xover_mutate_ctrl_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-1:0]    child_count
);
  localparam int unsigned RC_W = (NUM_RND > 1) ? $clog2(NUM_RND) : 1;

  state_e                           state_q, state_d;
  logic [ADDR_W-1:0]                idx_q, idx_d, cnt_q, cnt_d, cc_q, cc_d, idx_inc;
  logic                             bias_q, bias_d;
  logic [7:0]                       prob_q, prob_d;
  logic [GENE_SZ-1:0]               del_q, del_d, g1_q, g1_d, g2_q, g2_d, child_q, child_d;
  logic [NUM_RND-1:0][ATTR_SZ-1:0]  rnd_q, rnd_d;
  logic [RC_W-1:0]                  rcnt_q, rcnt_d;
  logic [GENE_SZ-1:0]               comp_child;
  logic                             comp_skip, last_gene;

  gene_child_compose u_compose (
    .gene1         (g1_q),
    .gene2         (g2_q),
    .bias          (bias_q),
    .mutation_prob (prob_q),
    .del_node_list (del_q),
    .rnd           (rnd_q),
    .child         (comp_child),
    .skip          (comp_skip)
  );

  assign idx_inc   = idx_q + 1'b1;
  assign last_gene = (idx_inc == cnt_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    cc_d    = cc_q;
    bias_d  = bias_q;
    prob_d  = prob_q;
    del_d   = del_q;
    g1_d    = g1_q;
    g2_d    = g2_q;
    rnd_d   = rnd_q;
    rcnt_d  = rcnt_q;
    child_d = child_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = gene_count;
          bias_d  = bias;
          prob_d  = mutation_prob;
          del_d   = del_node_list;
          idx_d   = '0;
          cc_d    = '0;
          state_d = (gene_count == '0) ? S_DONE : S_READ;
        end
      end
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: begin
        g1_d    = bus.p1_rd_data;
        g2_d    = bus.p2_rd_data;
        rcnt_d  = '0;
        state_d = S_RAND;
      end
      S_RAND: begin
        if (bus.rnd_valid) begin
          rnd_d[rcnt_q] = bus.rnd_data;
          rcnt_d        = rcnt_q + 1'b1;
          if (rcnt_q == RC_W'(NUM_RND - 1)) state_d = S_COMPOSE;
        end
      end
      // A deleted gene bypasses WRITE entirely and advances straight to the next pair.
      S_COMPOSE: begin
        child_d = comp_child;
        if (comp_skip) begin
          idx_d   = idx_inc;
          state_d = last_gene ? S_DONE : S_READ;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus.child_wr_ready) begin
          cc_d    = cc_q + 1'b1;
          idx_d   = idx_inc;
          state_d = last_gene ? S_DONE : S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      cc_q    <= '0;
      bias_q  <= 1'b0;
      prob_q  <= '0;
      del_q   <= '0;
      g1_q    <= '0;
      g2_q    <= '0;
      rnd_q   <= '0;
      rcnt_q  <= '0;
      child_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      cc_q    <= cc_d;
      bias_q  <= bias_d;
      prob_q  <= prob_d;
      del_q   <= del_d;
      g1_q    <= g1_d;
      g2_q    <= g2_d;
      rnd_q   <= rnd_d;
      rcnt_q  <= rcnt_d;
      child_q <= child_d;
    end
  end

  assign bus.p1_rd_en      = (state_q == S_READ);
  assign bus.p2_rd_en      = (state_q == S_READ);
  assign bus.p_addr        = idx_q;
  assign bus.rnd_req       = (state_q == S_RAND);
  assign bus.child_wr_en   = (state_q == S_WRITE);
  assign bus.child_addr    = cc_q;
  assign bus.child_wr_data = child_q;
  assign busy              = (state_q != S_IDLE);
  assign done              = (state_q == S_DONE);
  assign child_count       = cc_q;
endmodule
